// File: rtl/hpm_sampler.sv
// Periodic sampler for the HPM counters: shares the counter access port with the CSR file
// (CSR always wins) and streams (index, value) snapshots. Threshold IRQ under HPM_SAMPLER_IRQ_EN.
module hpm_sampler #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned PeriodWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   csr_req_i,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [XLEN-1:0]        csr_wdata_i,
  output logic [XLEN-1:0]        csr_rdata_o,
  output logic [11:0]            pc_addr_o,
  output logic                   pc_we_o,
  output logic [XLEN-1:0]        pc_wdata_o,
  input  logic [XLEN-1:0]        pc_rdata_i,
  input  logic                   cfg_en_i,
  input  logic [PeriodWidth-1:0] cfg_period_i,
  input  logic [XLEN-1:0]        cfg_threshold_i,
  output logic                   snap_valid_o,
  output logic [2:0]             snap_idx_o,
  output logic [XLEN-1:0]        snap_data_o,
  input  logic                   snap_ready_i,
  output logic                   irq_o,
  input  logic                   irq_clr_i,
  output logic                   busy_o
);

  localparam int unsigned  IdxW    = 3;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCounters - 1);
  localparam logic [11:0]  CntBase = 12'hB03;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRead,
    StPush
  } state_e;

  state_e                 state_q, state_d;
  logic [PeriodWidth-1:0] timer_q, timer_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   snap_valid_q, snap_valid_d;
  logic [IdxW-1:0]        snap_idx_q, snap_idx_d;
  logic [XLEN-1:0]        snap_data_q, snap_data_d;
  logic                   busy_q, busy_d;
  logic                   capture_c;

  // Counter port mux: the CSR file owns the port whenever it requests it.
  always_comb begin
    pc_addr_o  = CntBase;
    pc_we_o    = 1'b0;
    pc_wdata_o = '0;
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
    end else if (state_q == StRead) begin
      pc_addr_o = CntBase + 12'(idx_q);
    end
  end

  assign csr_rdata_o = pc_rdata_i;

  // Sampler next-state logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    snap_valid_d = snap_valid_q;
    snap_idx_d   = snap_idx_q;
    snap_data_d  = snap_data_q;
    capture_c    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cfg_en_i) begin
          state_d = StWait;
          timer_d = cfg_period_i;
        end
      end
      StWait: begin
        if (!cfg_en_i) begin
          state_d = StIdle;
        end else if (timer_q == '0) begin
          state_d = StRead;
          idx_d   = '0;
        end else begin
          timer_d = timer_q - PeriodWidth'(1);
        end
      end
      StRead: begin
        if (!csr_req_i) begin
          capture_c    = 1'b1;
          snap_data_d  = pc_rdata_i;
          snap_idx_d   = idx_q;
          snap_valid_d = 1'b1;
          state_d      = StPush;
        end
      end
      StPush: begin
        if (snap_ready_i) begin
          snap_valid_d = 1'b0;
          if (idx_q < LastIdx) begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StRead;
          end else if (cfg_en_i) begin
            state_d = StWait;
            timer_d = cfg_period_i;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRead) || (state_d == StPush);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      idx_q        <= '0;
      snap_valid_q <= 1'b0;
      snap_idx_q   <= '0;
      snap_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      snap_valid_q <= snap_valid_d;
      snap_idx_q   <= snap_idx_d;
      snap_data_q  <= snap_data_d;
      busy_q       <= busy_d;
    end
  end

  assign snap_valid_o = snap_valid_q;
  assign snap_idx_o   = snap_idx_q;
  assign snap_data_o  = snap_data_q;
  assign busy_o       = busy_q;

`ifdef HPM_SAMPLER_IRQ_EN
  logic [XLEN-1:0]        prev_q [NumCounters];
  logic [NumCounters-1:0] pend_q, pend_d;
  logic                   irq_q;

  // Upward threshold crossing against the previous sample; a new set beats a clear.
  always_comb begin
    pend_d = irq_clr_i ? '0 : pend_q;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (capture_c && (idx_q == IdxW'(i)) &&
          (prev_q[i] < cfg_threshold_i) && (pc_rdata_i >= cfg_threshold_i)) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
      for (int unsigned i = 0; i < NumCounters; i++) begin
        prev_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
      for (int unsigned i = 0; i < NumCounters; i++) begin
        if (capture_c && (idx_q == IdxW'(i))) begin
          prev_q[i] <= pc_rdata_i;
        end
      end
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{cfg_threshold_i, irq_clr_i};
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_sampler.sv
// Scoreboard bench for hpm_sampler: expected snapshots are queued from a sample-level model
// and a monitor pops/compares them on every snapshot handshake.
module tb_hpm_sampler;
  localparam int unsigned NUM  = 6;
  localparam int unsigned XL   = 64;
  localparam int unsigned PW   = 16;
  localparam logic [11:0] BASE = 12'hB03;
`ifdef HPM_SAMPLER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk_i;
  logic          rst_ni;
  logic          csr_req_i, csr_we_i;
  logic [11:0]   csr_addr_i;
  logic [XL-1:0] csr_wdata_i, csr_rdata_o;
  logic [11:0]   pc_addr_o;
  logic          pc_we_o;
  logic [XL-1:0] pc_wdata_o, pc_rdata_i;
  logic          cfg_en_i;
  logic [PW-1:0] cfg_period_i;
  logic [XL-1:0] cfg_threshold_i;
  logic          snap_valid_o;
  logic [2:0]    snap_idx_o;
  logic [XL-1:0] snap_data_o;
  logic          snap_ready_i;
  logic          irq_o, irq_clr_i, busy_o;

  hpm_sampler #(.NumCounters(NUM), .XLEN(XL), .PeriodWidth(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .pc_addr_o(pc_addr_o), .pc_we_o(pc_we_o), .pc_wdata_o(pc_wdata_o), .pc_rdata_i(pc_rdata_i),
    .cfg_en_i(cfg_en_i), .cfg_period_i(cfg_period_i), .cfg_threshold_i(cfg_threshold_i),
    .snap_valid_o(snap_valid_o), .snap_idx_o(snap_idx_o), .snap_data_o(snap_data_o),
    .snap_ready_i(snap_ready_i), .irq_o(irq_o), .irq_clr_i(irq_clr_i), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Counter block: combinational read, write on the clock edge.
  logic [XL-1:0] mem [NUM];
  int unsigned   rd_off;
  assign rd_off = 32'(pc_addr_o) - 32'(BASE);
  always @(posedge clk_i) begin
    if (pc_we_o && (rd_off < NUM)) mem[rd_off] <= pc_wdata_o;
  end
  always_comb begin
    if (rd_off < NUM) pc_rdata_i = mem[rd_off];
    else              pc_rdata_i = 64'hDEAD_0000_0000_0000 | 64'(pc_addr_o);
  end

  typedef struct packed {
    logic [2:0]    idx;
    logic [XL-1:0] data;
    logic          irq;
  } snap_t;

  snap_t          exp_q[$];
  int             checks = 0;
  int             errors = 0;
  logic [XL-1:0]  exp_cnt [NUM];
  logic [XL-1:0]  prev_m  [NUM];
  logic [NUM-1:0] pend_m;
  logic [XL-1:0]  thr_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_thr(input logic [XL-1:0] v);
    thr_m = v;
    cfg_threshold_i = v;
  endtask

  task automatic model_reset;
    for (int i = 0; i < NUM; i++) prev_m[i] = '0;
    pend_m = '0;
  endtask

  // One burst of expected snapshots from the current counter contents.
  task automatic push_burst(input bit clr_mode);
    for (int i = 0; i < NUM; i++) begin
      snap_t s;
      bit    crossed;
      crossed = (prev_m[i] < thr_m) && (exp_cnt[i] >= thr_m);
      if (clr_mode) pend_m = '0;
      if (crossed) pend_m[i] = 1'b1;
      prev_m[i] = exp_cnt[i];
      s.idx  = 3'(i);
      s.data = exp_cnt[i];
      s.irq  = IRQ_EN ? (|pend_m) : 1'b0;
      exp_q.push_back(s);
    end
    if (clr_mode) pend_m = '0;
  endtask

  task automatic write_cnt(input int i, input logic [XL-1:0] v);
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = BASE + 12'(i); csr_wdata_i = v;
    #1;
    chk("wr_mux_addr", 64'(pc_addr_o), 64'(BASE + 12'(i)));
    chk("wr_mux_we", 64'(pc_we_o), 64'd1);
    chk("wr_mux_wdata", pc_wdata_o, v);
    tick;
    csr_req_i = 1'b0; csr_we_i = 1'b0;
    exp_cnt[i] = v;
  endtask

  task automatic read_chk(input int i);
    csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = BASE + 12'(i);
    #1;
    chk("csr_rdata", csr_rdata_o, exp_cnt[i]);
    tick;
    csr_req_i = 1'b0;
  endtask

  task automatic rand_io(input int rdy_pct, input int csr_pct, input bit clr_mode);
    snap_ready_i = clr_mode || (int'($urandom_range(99)) < rdy_pct);
    csr_req_i    = int'($urandom_range(99)) < csr_pct;
    csr_we_i     = csr_req_i && ($urandom_range(1) == 1);
    csr_addr_i   = csr_we_i ? 12'h300 + 12'($urandom_range(255)) : 12'($urandom);
    csr_wdata_i  = {$urandom, $urandom};
  endtask

  task automatic wait_busy(input logic lvl, input int max_cyc, input int rdy_pct,
                           input int csr_pct, input bit clr_mode, input string name);
    int n = 0;
    while ((busy_o !== lvl) && (n < max_cyc)) begin
      tick;
      rand_io(rdy_pct, csr_pct, clr_mode);
      n++;
    end
    if (busy_o !== lvl) chk(name, 64'(busy_o), 64'(lvl));
  endtask

  task automatic idle_io;
    csr_req_i = 1'b0; csr_we_i = 1'b0; snap_ready_i = 1'b1;
  endtask

  // Single burst: enable, drop enable somewhere inside the burst, drain to idle.
  task automatic run_burst(input bit clr_mode, input int rdy_pct, input int csr_pct, input int period);
    push_burst(clr_mode);
    irq_clr_i    = clr_mode;
    cfg_period_i = PW'(period);
    cfg_en_i     = 1'b1;
    wait_busy(1'b1, 200, rdy_pct, csr_pct, clr_mode, "burst_start_timeout");
    for (int k = 0; k < int'($urandom_range(3)); k++) begin
      tick;
      rand_io(rdy_pct, csr_pct, clr_mode);
    end
    cfg_en_i = 1'b0;
    wait_busy(1'b0, 3000, rdy_pct, csr_pct, clr_mode, "burst_end_timeout");
    idle_io();
    tick;
    irq_clr_i = 1'b0;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("irq_idle", 64'(irq_o), 64'(IRQ_EN ? (|pend_m) : 1'b0));
  endtask

  // Monitor: stability under backpressure, then scoreboard compare on handshake.
  bit    held;
  snap_t held_s;
  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        held = 1'b0;
      end else if (snap_valid_o) begin
        if (held) begin
          chk("snap_idx_stable", 64'(snap_idx_o), 64'(held_s.idx));
          chk("snap_data_stable", snap_data_o, held_s.data);
        end
        if (snap_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_snapshot idx=%0d data=%h", snap_idx_o, snap_data_o);
          end else begin
            snap_t e;
            e = exp_q.pop_front();
            chk("snap_idx", 64'(snap_idx_o), 64'(e.idx));
            chk("snap_data", snap_data_o, e.data);
            chk("snap_irq", 64'(irq_o), 64'(e.irq));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_s.idx  = snap_idx_o;
          held_s.data = snap_data_o;
          held_s.irq  = 1'b0;
        end
      end else if (held) begin
        chk("snap_valid_dropped", 64'(snap_valid_o), 64'd1);
        held = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n, first_v, hi, lo, phase;
    rst_ni = 1'b0; idle_io(); csr_addr_i = '0; csr_wdata_i = '0;
    cfg_en_i = 1'b0; cfg_period_i = '0; irq_clr_i = 1'b0;
    set_thr('1);
    model_reset();
    for (int i = 0; i < NUM; i++) exp_cnt[i] = '0;
    repeat (3) tick;
    chk("rst_valid", 64'(snap_valid_o), 64'd0);
    chk("rst_idx", 64'(snap_idx_o), 64'd0);
    chk("rst_data", snap_data_o, 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    rst_ni = 1'b1;
    tick;
    chk("idle_addr", 64'(pc_addr_o), 64'(BASE));
    chk("idle_we", 64'(pc_we_o), 64'd0);
    chk("idle_wdata", pc_wdata_o, 64'd0);

    // Basic burst: 10..15, period 3, ready held; latency, burst length and gap.
    for (int i = 0; i < NUM; i++) write_cnt(i, 64'(10 + i));
    read_chk(4);
    push_burst(1'b0);
    push_burst(1'b0);
    cfg_period_i = 16'd3;
    cfg_en_i = 1'b1;
    first_v = -1; hi = 0; lo = 0; phase = 0;
    for (int k = 1; (k <= 60) && (phase < 3); k++) begin
      tick;
      if ((first_v < 0) && snap_valid_o) first_v = k;
      case (phase)
        0: if (busy_o) begin hi = 1; phase = 1; end
        1: if (busy_o) hi++; else begin lo = 1; phase = 2; end
        default: if (!busy_o) lo++; else phase = 3;
      endcase
    end
    cfg_en_i = 1'b0;
    chk("first_valid_latency", 64'(first_v), 64'd6);
    chk("burst_busy_cycles", 64'(hi), 64'(2 * NUM));
    chk("burst_gap_cycles", 64'(lo), 64'd4);
    wait_busy(1'b0, 100, 100, 0, 1'b0, "basic_end_timeout");
    idle_io();
    tick;
    chk("basic_drained", 64'(exp_q.size()), 64'd0);

    // CSR priority at READ idx2, then backpressure at idx3.
    push_burst(1'b0);
    cfg_period_i = 16'd2;
    cfg_en_i = 1'b1;
    n = 0;
    while (!(busy_o && !snap_valid_o && (pc_addr_o == BASE + 12'd2)) && (n < 100)) begin
      tick;
      n++;
    end
    chk("reach_read_idx2", 64'(n < 100), 64'd1);
    for (int k = 0; k < 5; k++) begin
      csr_req_i   = 1'b1;
      csr_we_i    = (k == 2);
      csr_addr_i  = (k == 2) ? BASE + 12'd1 : 12'h340 + 12'(k);
      csr_wdata_i = (k == 2) ? 64'h55 : {$urandom, $urandom};
      #1;
      chk("stall_addr", 64'(pc_addr_o), 64'(csr_addr_i));
      chk("stall_no_valid", 64'(snap_valid_o), 64'd0);
      if (k == 2) chk("stall_wdata", pc_wdata_o, 64'h55);
      tick;
    end
    csr_req_i = 1'b0; csr_we_i = 1'b0;
    exp_cnt[1] = 64'h55;
    #1;
    chk("resume_addr", 64'(pc_addr_o), 64'(BASE + 12'd2));
    tick;
    chk("resume_valid", 64'(snap_valid_o), 64'd1);
    chk("resume_idx", 64'(snap_idx_o), 64'd2);
    n = 0;
    while (!(snap_valid_o && (snap_idx_o == 3'd3)) && (n < 20)) begin
      tick;
      n++;
    end
    snap_ready_i = 1'b0;
    cfg_en_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("bp_valid", 64'(snap_valid_o), 64'd1);
      chk("bp_idx", 64'(snap_idx_o), 64'd3);
      chk("bp_no_read", 64'(pc_addr_o), 64'(BASE));
      tick;
    end
    snap_ready_i = 1'b1;
    tick;
    chk("after_bp_addr", 64'(pc_addr_o), 64'(BASE + 12'd4));
    chk("after_bp_valid", 64'(snap_valid_o), 64'd0);
    wait_busy(1'b0, 100, 100, 0, 1'b0, "bp_end_timeout");
    tick;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    read_chk(1);

    // Enable drop while waiting: no burst may follow.
    cfg_period_i = 16'd10;
    cfg_en_i = 1'b1;
    repeat (2) tick;
    cfg_en_i = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (busy_o || snap_valid_o) n++;
    end
    chk("wait_drop_no_burst", 64'(n), 64'd0);

    // Threshold scenarios: cross, clear-vs-set, wrap, re-cross.
    set_thr(64'd100);
    for (int i = 0; i < NUM; i++) write_cnt(i, 64'd0);
    write_cnt(0, 64'd90);
    run_burst(1'b0, 100, 0, 1);
    write_cnt(0, 64'd120);
    run_burst(1'b0, 100, 0, 1);
    write_cnt(1, 64'd200);
    run_burst(1'b1, 100, 0, 0);
    write_cnt(0, 64'd5);
    run_burst(1'b0, 100, 0, 2);
    write_cnt(0, 64'd150);
    run_burst(1'b0, 70, 20, 1);

    // Randomized bursts.
    for (int b = 0; b < 25; b++) begin
      set_thr(64'($urandom_range(1500, 500)));
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(1) == 1) begin
          logic [XL-1:0] v;
          case ($urandom_range(3))
            0, 1:    v = 64'($urandom_range(2000));
            2:       v = 64'($urandom);
            default: v = {$urandom, $urandom};
          endcase
          write_cnt(i, v);
        end
      end
      run_burst($urandom_range(4) == 0, int'($urandom_range(100, 30)),
                int'($urandom_range(50)), int'($urandom_range(4)));
    end

    // Reset in the middle of a held snapshot; burst restarts from idx 0.
    snap_ready_i = 1'b0;
    cfg_period_i = 16'd1;
    cfg_en_i = 1'b1;
    n = 0;
    while (!snap_valid_o && (n < 50)) begin
      tick;
      n++;
    end
    chk("pre_reset_valid", 64'(snap_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(snap_valid_o), 64'd0);
    chk("async_rst_irq", 64'(irq_o), 64'd0);
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    chk("async_rst_data", snap_data_o, 64'd0);
    exp_q.delete();
    model_reset();
    push_burst(1'b0);
    repeat (2) tick;
    rst_ni = 1'b1;
    wait_busy(1'b1, 50, 60, 10, 1'b0, "restart_timeout");
    cfg_en_i = 1'b0;
    wait_busy(1'b0, 1000, 60, 10, 1'b0, "restart_end_timeout");
    idle_io();
    tick;
    chk("restart_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpm_sampler.md
# hpm_sampler

Periodic sampling controller for the hardware performance-monitor counters (mhpmcounter3..). It owns the counter block's SRAM-like access port and shares it between the CSR file, which always has priority, and an internal sampler. The sampler walks all counters every programmed period and streams (index, value) snapshots over a valid/ready interface. An optional threshold-crossing interrupt can be compiled in.

## Interface
Parameters:
- NumCounters, 6, number of HPM counters sampled (1..8)
- XLEN, 64, counter/data width
- PeriodWidth, 16, width of the sampling period timer

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- csr_req_i  in  1  CSR file access this cycle
- csr_we_i  in  1  CSR write
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  CSR write data
- csr_rdata_o  out  XLEN  CSR read data
- pc_addr_o  out  12  address to counter block
- pc_we_o  out  1  write enable to counter block
- pc_wdata_o  out  XLEN  write data to counter block
- pc_rdata_i  in  XLEN  combinational read data from counter block
- cfg_en_i  in  1  sampler enable
- cfg_period_i  in  PeriodWidth  idle cycles between bursts
- cfg_threshold_i  in  XLEN  interrupt threshold (unsigned)
- snap_valid_o  out  1  snapshot valid
- snap_idx_o  out  3  counter index, 0 = mhpmcounter3
- snap_data_o  out  XLEN  counter value
- snap_ready_i  in  1  consumer accepts snapshot
- irq_o  out  1  threshold-crossing interrupt
- irq_clr_i  in  1  clear all pending interrupt bits
- busy_o  out  1  burst in progress (READ or PUSH)

## Operation
- Port mux, combinational: csr_req_i=1 → pc_addr_o=csr_addr_i, pc_we_o=csr_we_i, pc_wdata_o=csr_wdata_i. Otherwise pc_addr_o = 12'hB03+idx in READ, else 12'hB03; pc_we_o=0; pc_wdata_o=0. csr_rdata_o=pc_rdata_i always. The sampler never writes.
- FSM states IDLE, WAIT, READ, PUSH:
  - IDLE: cfg_en_i=1 → WAIT with timer loaded from cfg_period_i.
  - WAIT: cfg_en_i=0 → IDLE. Timer==0 → READ with idx=0. Otherwise decrement the timer.
  - READ: csr_req_i=1 → stall in READ. Otherwise capture pc_rdata_i into snap_data_o, set snap_idx_o=idx and snap_valid_o=1, then → PUSH.
  - PUSH: hold all snap_* stable until snap_ready_i=1. On acceptance, clear snap_valid_o. If idx<NumCounters-1: idx++ → READ. Else: cfg_en_i ? WAIT (timer reloaded) : IDLE.
- Deasserting cfg_en_i during READ/PUSH finishes the current burst. Bursts are never truncated.
- Threshold (macro enabled): per-counter prev[NumCounters] register.
  - On each capture: if prev[idx] < cfg_threshold_i and value >= cfg_threshold_i, set pend[idx].
  - prev[idx] is updated to the captured value on every capture.
  - irq_o = |pend, registered.
  - irq_clr_i clears pend. A set in the same cycle wins.
  - A counter wrap (value < prev) never sets pend by itself. The next upward crossing does.
  - CSR writes to counters do not update prev.

## Timing
- Reset values: FSM=IDLE, timer=0, idx=0, snap_valid_o=0, snap_idx_o=0, snap_data_o=0, pend=0, prev=0, irq_o=0, busy_o=0.
- Mux and csr_rdata_o have zero latency.
- Timer reaches 0 in cycle T → READ at T+1 → snap_valid_o=1 at T+2, absent CSR contention.
- Period P: first READ comes P+1 cycles after entering WAIT.
- Each CSR-busy cycle in READ adds one cycle.
- Each counter costs at least 2 cycles (READ and PUSH with immediate ready). A full burst with ready held high is 2·NumCounters cycles.
- irq_o rises the cycle after the crossing capture, i.e. together with that snapshot's snap_valid_o.
- busy_o is high exactly in READ and PUSH.
- Reset asserted mid-burst: everything returns to reset values asynchronously and no partial snapshot remains valid.

## Configuration
- HPM_SAMPLER_IRQ_EN defined: prev/pend registers, the threshold compare and irq_o behave as above.
- HPM_SAMPLER_IRQ_EN undefined: no prev/pend storage. irq_o is tied 0, and cfg_threshold_i and irq_clr_i are ignored. Sampling and port muxing are unchanged.

## Test plan
- Basic burst: NumCounters=6, period=3, ready held 1, counters preloaded 10..15 → snapshots idx 0..5 carry 10..15 on consecutive PUSH cycles; first valid 6 cycles after enable; next burst starts 4 cycles after the last handshake.
- CSR priority: csr_req_i=1 for 5 cycles during READ idx=2 → pc_addr_o follows csr_addr_i, the sampler holds, then samples addr 12'hB05; CSR write of 0x55 to 12'hB04 reaches the counter unaltered.
- Backpressure: snap_ready_i=0 for 7 cycles at idx=3 → snap_valid_o, snap_idx_o=3 and snap_data_o stay stable; idx 4 is read only after the handshake.
- Enable drop: cfg_en_i falls at idx=1 → all 6 snapshots are still emitted, then IDLE with busy_o=0; a drop in WAIT → IDLE next cycle with no snapshot.
- Threshold (macro on): thr=100, counter 0 samples 90 then 120 → irq_o=1; irq_clr_i while counter 1 crosses → irq_o stays 1; sample sequence 120, 5 (wrap) → no new set; then 150 → set.
- Reset mid-PUSH: assert rst_ni=0 with snap_valid_o=1 → snap_valid_o=0 and irq_o=0 immediately; after release with cfg_en_i=1, the burst restarts from idx 0.
